// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer_if
// Description : Load handshake and serial output bundle for piso_serializer.
//               slave  - serializer side (accepts words, drives serial bits)
//               master - producer/consumer side (offers words, observes bits)
//   load_valid : word offered on load_data
//   load_data  : WIDTH-bit parallel word
//   load_ready : serializer can accept a word
//   ser_out    : serial data bit
//   ser_valid  : ser_out carries a data bit
//   done       : one-cycle word-completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             done;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  done
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output ser_out,
        output ser_valid,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in / serial-out shifter with a two-state FSM.
//               A word is accepted from the load handshake while IDLE, then
//               shifted out one bit per enabled clock, head bit first.
//   clk         : sole clock, rising edge
//   async_reset : asynchronous active-high reset
//   sync_reset  : synchronous active-high clear (beats load and enable)
//   enable      : bit-advance strobe while shifting
//   bus         : load handshake and serial outputs (slave modport)
// Parameters  : WIDTH (2..32), MSB_FIRST (1 = MSB first), IDLE_LEVEL
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  wire                  clk,
    input  wire                  async_reset,
    input  wire                  sync_reset,
    input  wire                  enable,
    piso_serializer_if.slave     bus
);

    localparam int               c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_shift = 1'b1;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_done;

    logic [0:0]         w_state_nxt;
    logic [WIDTH-1:0]   w_shreg_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_done_nxt;

    // Head bit currently presented, and the register moved one step toward it.
    logic               w_head;
    logic [WIDTH-1:0]   w_shifted;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_head    = r_shreg[WIDTH-1];
            assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_head    = r_shreg[0];
            assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_state <= c_st_idle;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;

        if (sync_reset) begin
            w_state_nxt = c_st_idle;
            w_shreg_nxt = '0;
            w_cnt_nxt   = '0;
        end else if (r_state == c_st_idle) begin
            // load_ready is high throughout IDLE, so load_valid alone accepts;
            // enable is deliberately ignored on the accepting edge.
            if (bus.load_valid) begin
                w_shreg_nxt = bus.load_data;
                w_cnt_nxt   = '0;
                w_state_nxt = c_st_shift;
            end
        end else begin
            if (enable) begin
                w_shreg_nxt = w_shifted;
                if (r_cnt == c_last_cnt) begin
                    // Last bit leaves on this edge: done lands in the first
                    // IDLE cycle, where a new word may already be accepted.
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.load_ready = (r_state == c_st_idle);
    assign bus.ser_valid  = (r_state == c_st_shift);
    assign bus.ser_out    = (r_state == c_st_shift) ? w_head : IDLE_LEVEL;
    assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Self-checking bench for piso_serializer. Two instances share
//               one stimulus: dut_m (MSB first, idle 0) and dut_l (LSB first,
//               idle 1). Directed vectors come from a table, corner cases are
//               hand sequenced, and random traffic is scored against a
//               bit-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic async_reset;
    logic sync_reset;
    logic enable;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(W)) bus_m ();
    piso_serializer_if #(.WIDTH(W)) bus_l ();

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk         (clk),
        .async_reset (async_reset),
        .sync_reset  (sync_reset),
        .enable      (enable),
        .bus         (bus_m.slave)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
        .clk         (clk),
        .async_reset (async_reset),
        .sync_reset  (sync_reset),
        .enable      (enable),
        .bus         (bus_l.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model: queues of bits still to be sent ----
    bit qm[$];
    bit ql[$];
    bit m_busy;
    bit m_done;

    function automatic void model_reset();
        qm.delete();
        ql.delete();
        m_busy = 1'b0;
        m_done = 1'b0;
    endfunction

    function automatic void model_edge(bit sr, bit en, bit lv, logic [W-1:0] d);
        if (sr) begin
            model_reset();
            return;
        end
        m_done = 1'b0;
        if (!m_busy) begin
            if (lv) begin
                qm.delete();
                ql.delete();
                for (int i = 0; i < W; i++) begin
                    qm.push_back(d[W-1-i]);
                    ql.push_back(d[i]);
                end
                m_busy = 1'b1;
            end
        end else if (en) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
            if (qm.size() == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    endfunction

    // Packed as {ready, valid, ser, done} for dut_m then for dut_l.
    function automatic logic [7:0] mk(bit rdy, bit vld, bit sm, bit sl, bit dn);
        return {rdy, vld, sm, dn, rdy, vld, sl, dn};
    endfunction

    function automatic logic [7:0] model_out();
        bit sm;
        bit sl;
        sm = m_busy ? qm[0] : 1'b0;
        sl = m_busy ? ql[0] : 1'b1;
        return mk(!m_busy, m_busy, sm, sl, m_done);
    endfunction

    function automatic logic [7:0] dut_out();
        return {bus_m.load_ready, bus_m.ser_valid, bus_m.ser_out, bus_m.done,
                bus_l.load_ready, bus_l.ser_valid, bus_l.ser_out, bus_l.done};
    endfunction

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = dut_out();
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got rdy/vld/ser/done m=%b l=%b, expected m=%b l=%b",
                     name, $time, act[7:4], act[3:0], exp[7:4], exp[3:0]);
        end
    endtask

    // Drive inputs just after an edge, take the next edge, advance the model.
    task automatic step(input bit sr, input bit en, input bit lv, input logic [W-1:0] d);
        sync_reset       = sr;
        enable           = en;
        bus_m.load_valid = lv;
        bus_l.load_valid = lv;
        bus_m.load_data  = d;
        bus_l.load_data  = d;
        @(posedge clk);
        model_edge(sr, en, lv, d);
        #1;
    endtask

    task automatic mstep(input string name, input bit sr, input bit en, input bit lv,
                         input logic [W-1:0] d);
        step(sr, en, lv, d);
        check(name, model_out());
    endtask

    // Pulse async_reset between edges and check that outputs drop at once.
    task automatic async_pulse(input string name);
        async_reset = 1'b1;
        model_reset();
        #1;
        check(name, model_out());
        #1;
        async_reset = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          sr;
        bit          en;
        bit          lv;
        logic [W-1:0] d;
        logic [7:0]  exp;
    } vec_t;

    vec_t tab[$];

    function automatic void add(bit sr, bit en, bit lv, logic [W-1:0] d, logic [7:0] exp);
        vec_t v;
        v.sr = sr; v.en = en; v.lv = lv; v.d = d; v.exp = exp;
        tab.push_back(v);
    endfunction

    initial begin
        logic [W-1:0] seq_a5;
        logic [W-1:0] seq_01_m;
        logic [W-1:0] seq_01_l;

        async_reset      = 1'b1;
        sync_reset       = 1'b0;
        enable           = 1'b0;
        bus_m.load_valid = 1'b0;
        bus_l.load_valid = 1'b0;
        bus_m.load_data  = '0;
        bus_l.load_data  = '0;
        model_reset();

        // Expected serial sequences, listed first bit on the left.
        seq_a5   = 8'b10100101;   // 8'hA5, same for both orders
        seq_01_m = 8'b00000001;   // 8'h01 MSB first
        seq_01_l = 8'b10000000;   // 8'h01 LSB first

        // A5 with enable held high (enable on the accepting edge is ignored).
        add(0, 1, 1, 8'hA5, mk(0, 1, seq_a5[7], seq_a5[7], 0));
        for (int i = 1; i < W; i++)
            add(0, 1, 0, 8'h00, mk(0, 1, seq_a5[7-i], seq_a5[7-i], 0));
        add(0, 1, 0, 8'h00, mk(1, 0, 0, 1, 1));
        add(0, 1, 0, 8'h00, mk(1, 0, 0, 1, 0));
        // 8'h01 with enable low on the accepting edge.
        add(0, 0, 1, 8'h01, mk(0, 1, seq_01_m[7], seq_01_l[7], 0));
        for (int i = 1; i < W; i++)
            add(0, 1, 0, 8'h00, mk(0, 1, seq_01_m[7-i], seq_01_l[7-i], 0));
        add(0, 1, 0, 8'h00, mk(1, 0, 0, 1, 1));
        // sync_reset together with load_valid in IDLE: load refused.
        add(1, 1, 1, 8'h5A, mk(1, 0, 0, 1, 0));
        add(0, 0, 0, 8'h00, mk(1, 0, 0, 1, 0));

        #1;
        check("reset_state", mk(1, 0, 0, 1, 0));
        @(posedge clk);
        #1;
        async_reset = 1'b0;

        // First edge after reset release accepts the table's first load.
        foreach (tab[k]) begin
            step(tab[k].sr, tab[k].en, tab[k].lv, tab[k].d);
            check($sformatf("table[%0d]", k), tab[k].exp);
        end

        // F0 with enable on every third edge: each bit held for 3 cycles.
        mstep("slow_load", 0, 0, 1, 8'hF0);
        for (int i = 0; i < 3 * W; i++)
            mstep("slow_shift", 0, (i % 3) == 2, 0, 8'h00);
        mstep("slow_after", 0, 1, 0, 8'h00);

        // 3C offered during A5 is ignored, then taken in the done cycle.
        mstep("b2b_load", 0, 1, 1, 8'hA5);
        for (int i = 0; i < W; i++)
            mstep("b2b_busy", 0, 1, 1, 8'h3C);
        check("b2b_done", mk(1, 0, 0, 1, 1));
        mstep("b2b_second", 0, 1, 1, 8'h3C);
        for (int i = 0; i < W + 1; i++)
            mstep("b2b_shift2", 0, 1, 0, 8'h00);

        // async_reset at bit 4 of FF, then a fresh 81.
        mstep("abort_load", 0, 1, 1, 8'hFF);
        for (int i = 0; i < 4; i++)
            mstep("abort_shift", 0, 1, 0, 8'h00);
        async_pulse("abort_async");
        for (int i = 0; i < W + 2; i++)
            mstep("abort_nodone", 0, 1, 0, 8'h00);
        mstep("fresh_load", 0, 1, 1, 8'h81);
        for (int i = 0; i < W + 1; i++)
            mstep("fresh_shift", 0, 1, 0, 8'h00);

        // sync_reset mid-word aborts with no done pulse.
        mstep("sabort_load", 0, 1, 1, 8'hC3);
        for (int i = 0; i < 3; i++)
            mstep("sabort_shift", 0, 1, 0, 8'h00);
        mstep("sabort_sr", 1, 1, 1, 8'h77);
        for (int i = 0; i < W + 1; i++)
            mstep("sabort_after", 0, 1, 0, 8'h00);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            mstep("random", $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, W'($urandom));
            if ($urandom_range(0, 59) == 0)
                async_pulse("random_async");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
